ram_2port_loader: RTL and testbench

RAM_2PORT_LOADER -- requirements
Module: ram_2port_loader

---
 rtl/ram_2port_loader.sv | 158 +++++++++++++++
 tb/tb_ram_2port_loader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_2port_loader.sv
// Streaming loader that fills a dual-read-port RAM from a valid/ready source.
// Loads run from a latched base for a latched length, ending early on s_last.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   load_start           one-cycle start pulse, honoured only when idle
//   load_base/load_len   first write address / entry count (0..2**AWIDTH)
//   s_data/s_valid       incoming entry and its qualifier
//   s_ready              registered: high for the whole LOAD state
//   s_last               final entry of the producer's stream
//   busy, done           load in progress / one-cycle completion pulse
//   err_short            the last load was cut short by s_last
//   wr_count             entries written in the current or last load
//   address_a/b, q_a/b   two independent reads, 2-cycle latency
module ram_2port_loader #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [AWIDTH-1:0] load_base,
  input  logic [AWIDTH:0]   load_len,
  input  logic [DWIDTH-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  output logic              busy,
  output logic              done,
  output logic              err_short,
  output logic [AWIDTH:0]   wr_count,
  input  logic [AWIDTH-1:0] address_a,
  input  logic [AWIDTH-1:0] address_b,
  output logic [DWIDTH-1:0] q_a,
  output logic [DWIDTH-1:0] q_b
);

  localparam int DEPTH = 2 ** AWIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [AWIDTH:0]     wr_count_q, wr_count_d;
  logic [AWIDTH:0]     len_q, len_d;
  logic                err_q, err_d;

  logic                accept;
  logic                we;
  logic [AWIDTH:0]     cnt_inc;

  logic [DWIDTH-1:0]   mem [DEPTH];

  logic [AWIDTH-1:0]   ra_q, rb_q;
  logic [DWIDTH-1:0]   qa_q, qb_q;

  // s_ready comes straight from the state register, so there is
  // no combinational path from s_valid back to s_ready.
  assign s_ready   = (state_q == S_LOAD);
  assign busy      = s_ready;
  assign done      = (state_q == S_DONE);
  assign err_short = err_q;
  assign wr_count  = wr_count_q;
  assign q_a       = qa_q;
  assign q_b       = qb_q;

  assign accept  = s_valid && s_ready;
  assign cnt_inc = wr_count_q + (AWIDTH+1)'(1);

  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    wr_count_d = wr_count_q;
    len_d      = len_q;
    err_d      = err_q;
    we         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load_start) begin
          wr_addr_d  = load_base;
          wr_count_d = '0;
          len_d      = load_len;
          err_d      = 1'b0;
          if (load_len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          we         = 1'b1;
          wr_addr_d  = wr_addr_q + AWIDTH'(1);
          wr_count_d = cnt_inc;
          // Reaching the length wins over s_last: a stream that
          // ends exactly on time is not short.
          if (cnt_inc == len_q) begin
            state_d = S_DONE;
          end else if (s_last) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_addr_q  <= '0;
      wr_count_q <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      wr_count_q <= wr_count_d;
      len_q      <= len_d;
      err_q      <= err_d;
    end
  end

  // Storage is never reset; a beat coinciding with rst is dropped.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem[wr_addr_q] <= s_data;
    end
  end

  // Address register then data register. The array read uses the
  // pre-edge contents, so a same-cycle write returns old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra_q <= '0;
      rb_q <= '0;
      qa_q <= '0;
      qb_q <= '0;
    end else begin
      ra_q <= address_a;
      rb_q <= address_b;
      qa_q <= mem[ra_q];
      qb_q <= mem[rb_q];
    end
  end

endmodule

// File: tb/tb_ram_2port_loader.sv
// Self-checking bench for ram_2port_loader: directed and random loads
// against an array model of memory contents and load outcomes.
module tb_ram_2port_loader;

  localparam int DEPTH = 256;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_start;
  logic [7:0] load_base;
  logic [8:0] load_len;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       s_last;
  logic       busy;
  logic       done;
  logic       err_short;
  logic [8:0] wr_count;
  logic [7:0] address_a;
  logic [7:0] address_b;
  logic [7:0] q_a;
  logic [7:0] q_b;

  logic [7:0] mm [DEPTH];
  bit         mv [DEPTH];

  int n_cmp = 0;
  int n_err = 0;

  ram_2port_loader #(.DWIDTH(8), .AWIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .load_base(load_base),
    .load_len(load_len), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .busy(busy), .done(done),
    .err_short(err_short), .wr_count(wr_count),
    .address_a(address_a), .address_b(address_b),
    .q_a(q_a), .q_b(q_b)
  );

  always #5 clk = ~clk;

  // Drives one complete load. Expected length and error flag follow
  // directly from len and the beat index carrying s_last.
  task automatic do_load(input int base, input int len,
                         input int last_at, input int stall,
                         input bit fixed, input logic [7:0] d0);
    int n_exp, beats, cyc, tog, a;
    bit v, e_err;
    n_exp = (last_at >= 0 && last_at < len - 1) ? last_at + 1 : len;
    e_err = (n_exp < len);
    @(negedge clk);
    load_start = 1'b1;
    load_base  = base[7:0];
    load_len   = len[8:0];
    s_valid    = 1'($urandom_range(0, 1));
    s_data     = 8'($urandom);
    s_last     = 1'b0;
    @(negedge clk);
    load_start = 1'b0;
    beats = 0; cyc = 0; tog = 0;
    while (beats < n_exp && cyc < 2000) begin
      n_cmp++;
      if (busy !== 1'b1 || s_ready !== 1'b1 || done !== 1'b0
          || err_short !== 1'b0) begin
        n_err++;
        $display("FAIL load_status: busy=%b rdy=%b done=%b err=%b, want 1 1 0 0",
                 busy, s_ready, done, err_short);
      end
      n_cmp++;
      if (wr_count !== beats[8:0]) begin
        n_err++;
        $display("FAIL load_count: wr_count=%0d, want %0d", wr_count, beats);
      end
      case (stall)
        0:       v = 1'b1;
        1:       v = (tog % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      tog++;
      s_valid = v;
      s_data  = fixed ? d0 + beats[7:0] : 8'($urandom);
      s_last  = v ? (beats == last_at) : 1'($urandom_range(0, 1));
      if (v) begin
        a = (base + beats) % DEPTH;
        mm[a] = s_data;
        mv[a] = 1'b1;
        beats++;
      end
      cyc++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    n_cmp++;
    if (cyc >= 2000) begin
      n_err++;
      $display("FAIL load_timeout: beats=%0d, want %0d", beats, n_exp);
    end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse: done=%b busy=%b rdy=%b, want 1 0 0",
               done, busy, s_ready);
    end
    n_cmp++;
    if (wr_count !== n_exp[8:0] || err_short !== e_err) begin
      n_err++;
      $display("FAIL done_result: wr_count=%0d err=%b, want %0d %b",
               wr_count, err_short, n_exp, e_err);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || err_short !== e_err
        || wr_count !== n_exp[8:0]) begin
      n_err++;
      $display("FAIL after_done: done=%b busy=%b err=%b cnt=%0d, want 0 0 %b %0d",
               done, busy, err_short, wr_count, e_err, n_exp);
    end
  endtask

  // Pipelined reads: port A walks up, port B walks down, crossing
  // over the same address mid-stream. Data is due 2 cycles later.
  task automatic read_stream(input int start, input int cnt);
    int aa, ab;
    for (int k = 0; k < cnt + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        aa = (start + k - 2) % DEPTH;
        ab = (start + cnt - 1 - (k - 2) + 2 * DEPTH) % DEPTH;
        if (mv[aa]) begin
          n_cmp++;
          if (q_a !== mm[aa]) begin
            n_err++;
            $display("FAIL read_a[%0h]: q_a=%h, want %h", aa, q_a, mm[aa]);
          end
        end
        if (mv[ab]) begin
          n_cmp++;
          if (q_b !== mm[ab]) begin
            n_err++;
            $display("FAIL read_b[%0h]: q_b=%h, want %h", ab, q_b, mm[ab]);
          end
        end
      end
      address_a = 8'((start + k) % DEPTH);
      address_b = 8'((start + cnt - 1 - k + 2 * DEPTH) % DEPTH);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    load_start = 1'b0; load_base = '0; load_len = '0;
    s_data = '0; s_valid = 1'b0; s_last = 1'b0;
    address_a = 8'h33; address_b = 8'hcc;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || s_ready !== 1'b0 || done !== 1'b0
        || err_short !== 1'b0 || wr_count !== 9'd0
        || q_a !== 8'h00 || q_b !== 8'h00) begin
      n_err++;
      $display("FAIL reset_state: busy=%b rdy=%b done=%b err=%b cnt=%0d qa=%h qb=%h",
               busy, s_ready, done, err_short, wr_count, q_a, q_b);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    do_load(8'h10, 4, -1, 0, 1'b1, 8'hA0);
    read_stream(8'h10, 4);
  endtask

  task automatic test_wrap_stall();
    do_load(8'hFE, 3, -1, 1, 1'b1, 8'h01);
    read_stream(8'hFE, 3);
  endtask

  task automatic test_short();
    do_load(8'h20, 5, 1, 0, 1'b0, 8'h00);
    do_load(8'h30, 3, 2, 2, 1'b0, 8'h00);
    read_stream(8'h20, 2);
    read_stream(8'h30, 3);
  endtask

  task automatic test_zero();
    do_load(8'h50, 1, -1, 0, 1'b1, 8'h9C);
    do_load(8'h50, 0, -1, 0, 1'b0, 8'h00);
    read_stream(8'h50, 1);
  endtask

  task automatic test_collision();
    do_load(7, 1, -1, 0, 1'b1, 8'h11);
    @(negedge clk);
    load_start = 1'b1; load_base = 8'd7; load_len = 9'd1;
    address_a = 8'd7; address_b = 8'd7;
    @(negedge clk);
    load_start = 1'b0;
    s_valid = 1'b1; s_data = 8'h55; s_last = 1'b0;
    @(negedge clk);
    s_valid = 1'b0;
    n_cmp++;
    if (q_a !== 8'h11 || q_b !== 8'h11 || done !== 1'b1) begin
      n_err++;
      $display("FAIL collide_old: qa=%h qb=%h done=%b, want 11 11 1",
               q_a, q_b, done);
    end
    mm[7] = 8'h55;
    @(negedge clk);
    n_cmp++;
    if (q_a !== 8'h55 || q_b !== 8'h55) begin
      n_err++;
      $display("FAIL collide_new: qa=%h qb=%h, want 55 55", q_a, q_b);
    end
  endtask

  task automatic test_rst_abort();
    logic [7:0] d;
    do_load(8'h42, 1, -1, 0, 1'b1, 8'h77);
    @(negedge clk);
    load_start = 1'b1; load_base = 8'h40; load_len = 9'd4;
    @(negedge clk);
    load_start = 1'b0;
    d = 8'($urandom);
    s_valid = 1'b1; s_data = d; mm[8'h40] = d; mv[8'h40] = 1'b1;
    @(negedge clk);
    d = 8'($urandom);
    s_data = d; mm[8'h41] = d; mv[8'h41] = 1'b1;
    load_start = 1'b1; load_base = 8'h80; load_len = 9'd1;
    @(negedge clk);
    load_start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || wr_count !== 9'd2) begin
      n_err++;
      $display("FAIL ignore_start: busy=%b cnt=%0d, want 1 2", busy, wr_count);
    end
    s_data = 8'hEE;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    s_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || s_ready !== 1'b0 || done !== 1'b0
        || wr_count !== 9'd0 || err_short !== 1'b0 || q_a !== 8'h00) begin
      n_err++;
      $display("FAIL abort_state: busy=%b rdy=%b done=%b cnt=%0d err=%b qa=%h",
               busy, s_ready, done, wr_count, err_short, q_a);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL abort_nodone: done=%b busy=%b, want 0 0", done, busy);
      end
    end
    read_stream(8'h40, 3);
  endtask

  task automatic test_random();
    int base, len, last_at;
    for (int i = 0; i < 25; i++) begin
      base = $urandom_range(0, 255);
      len  = (i == 0) ? 256 : $urandom_range(0, 24);
      if ($urandom_range(0, 1) == 0 || len == 0) begin
        last_at = -1;
      end else begin
        last_at = $urandom_range(0, len - 1);
      end
      do_load(base, len, last_at, $urandom_range(0, 2), 1'b0, 8'h00);
      read_stream(base, (len > 0) ? len : 1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap_stall();
    test_short();
    test_zero();
    test_collision();
    test_rst_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
